// File: rtl/mem_if_pkg.sv
// Shared types for the 128-bit cache line interface.
// Holds the line/address widths, the responder FSM state encoding and the operation encoding.
package mem_if_pkg;

    localparam int LINE_W  = 128;
    localparam int LADDR_W = 28;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        GAP  = 2'd3
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/line_ram.sv
// Single-port line store with a synchronous read register.
// The read register only loads on read accesses, so it holds the last read line across writes.
import mem_if_pkg::*;

module line_ram #(
    parameter int DEPTH_LOG2 = 6,
    parameter int W          = LINE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [W-1:0]          wdata,
    output logic [W-1:0]          q
);

    logic [W-1:0] mem [2**DEPTH_LOG2];

    // Array contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (en && !we) begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/slow_mem_responder.sv
// Fixed-latency line memory responder for the cache line interface.
// Accepts one request at a time, answers with a one-cycle mem_ready pulse, and flags protocol violations.
import mem_if_pkg::*;

module slow_mem_responder #(
    parameter int LATENCY    = 5,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [LADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0]  mem_wdata,
    output logic [LINE_W-1:0]  mem_rdata,
    output logic               mem_ready,
    output logic               busy,
    output logic               proto_err,
    output logic [15:0]        req_count,
    output state_t             state
);

    state_t             state_next;
    logic [7:0]         cnt, cnt_next;
    op_t                op_q;
    logic [LADDR_W-1:0] addr_q;
    logic [LINE_W-1:0]  wdata_q;
    logic               load;
    logic               err_set;
    logic               req_ok;
    logic               ram_en;
    logic               ram_we;

    // The latched request is still valid only if the same single op is held at the same address.
    assign req_ok = ((op_q == OP_RD) ? (mem_read && !mem_write) : (mem_write && !mem_read))
                    && (mem_addr == addr_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        load       = 1'b0;
        err_set    = 1'b0;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read && mem_write) begin
                    err_set = 1'b1;
                end else if (mem_read || mem_write) begin
                    load       = 1'b1;
                    cnt_next   = 8'(LATENCY - 1);
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (!req_ok) begin
                    err_set    = 1'b1;
                    state_next = IDLE;
                end else if (cnt == 8'd0) begin
                    // Reads are fetched on the way into RESP so the data is valid with mem_ready.
                    ram_en     = (op_q == OP_RD);
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            RESP: begin
                ram_en     = (op_q == OP_WR);
                ram_we     = (op_q == OP_WR);
                state_next = GAP;
            end
            GAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q    <= OP_RD;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (load) begin
            op_q    <= mem_write ? OP_WR : OP_RD;
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            proto_err <= 1'b0;
            req_count <= '0;
        end else begin
            if (err_set) begin
                proto_err <= 1'b1;
            end
            if (state == RESP && req_count != 16'hFFFF) begin
                req_count <= req_count + 16'd1;
            end
        end
    end

    assign mem_ready = (state == RESP);
    assign busy      = (state == WAIT) || (state == RESP);

    line_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .W          (LINE_W)
    ) u_line_ram (
        .clk   (clk),
        .rst   (rst),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (addr_q[DEPTH_LOG2-1:0]),
        .wdata (wdata_q),
        .q     (mem_rdata)
    );

endmodule
